// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the EX/MEM pipeline register and the
// multi-cycle data-memory controller.
interface dmem_ctrl_if;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misalign_o;

  modport master (
    output memread_i, memwrite_i, addr_i, wdata_i,
    input  stall_o, rdata_o, misalign_o
  );

  modport slave (
    input  memread_i, memwrite_i, addr_i, wdata_i,
    output stall_o, rdata_o, misalign_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: stalls the pipeline for LATENCY+1 cycles
// per load/store and commits the access to an internal word array.
module dmem_ctrl #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        mem_we;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  req;
  logic                  misaligned;
  logic                  unused_addr;

  // Upper address bits are dropped on purpose, so addresses alias the array.
  assign idx         = bus.addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = ^bus.addr_i[31:DEPTH_LOG2+2];
  assign req         = bus.memread_i | bus.memwrite_i;
  assign misaligned  = bus.addr_i[1:0] != 2'b00;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          // A write wins over a simultaneous read; misaligned accesses are dropped.
          if (misaligned) begin
            rdata_d    = 32'd0;
            misalign_d = 1'b1;
          end else if (bus.memwrite_i) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx] <= bus.wdata_i;
    end
  end

  assign bus.stall_o    = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign bus.rdata_o    = rdata_q;
  assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at LATENCY=2 and one at
// LATENCY=1, sharing stimulus through a select.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;

  int compared;
  int mismatched;

  dmem_ctrl_if bus0 ();
  dmem_ctrl_if bus1 ();

  assign bus0.memread_i  = memread  & ~sel;
  assign bus0.memwrite_i = memwrite & ~sel;
  assign bus0.addr_i     = addr;
  assign bus0.wdata_i    = wdata;
  assign bus1.memread_i  = memread  & sel;
  assign bus1.memwrite_i = memwrite & sel;
  assign bus1.addr_i     = addr;
  assign bus1.wdata_i    = wdata;

  logic        stall_w;
  logic [31:0] rdata_w;
  logic        mis_w;

  assign stall_w = sel ? bus1.stall_o    : bus0.stall_o;
  assign rdata_w = sel ? bus1.rdata_o    : bus0.rdata_o;
  assign mis_w   = sel ? bus1.misalign_o : bus0.misalign_o;

  dmem_ctrl #(.DEPTH_LOG2(8), .LATENCY(2)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  dmem_ctrl #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request starting just after a rising edge, counts stall cycles
  // until the DONE cycle, samples results there and one cycle later.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output int stalls, output logic [31:0] rdata,
                            output logic mis, output logic mis_after);
    bit done;
    stalls    = 0;
    done      = 0;
    rdata     = 32'hX;
    mis       = 1'bX;
    mis_after = 1'bX;
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    wdata     = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall_w) begin
        stalls++;
      end else begin
        done  = 1;
        rdata = rdata_w;
        mis   = mis_w;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL access_timeout addr=%h: DONE not reached, actual stalls=%0d required <40", a, stalls);
    end
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    mis_after = mis_w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_access(input string name, input int stalls, input int exp_stalls,
                              input logic [31:0] rdata, input logic [31:0] exp_rdata,
                              input logic mis, input logic exp_mis, input logic mis_after);
    compared++;
    if (stalls !== exp_stalls) begin
      mismatched++;
      $display("[TB] FAIL %s_stall: actual %0d required %0d", name, stalls, exp_stalls);
    end
    compared++;
    if (rdata !== exp_rdata) begin
      mismatched++;
      $display("[TB] FAIL %s_rdata: actual %h required %h", name, rdata, exp_rdata);
    end
    compared++;
    if (mis !== exp_mis) begin
      mismatched++;
      $display("[TB] FAIL %s_misalign: actual %b required %b", name, mis, exp_mis);
    end
    compared++;
    if (mis_after !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_misalign_after: actual %b required 0", name, mis_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (bus0.stall_o !== 1'b0 || bus0.rdata_o !== 32'd0 || bus0.misalign_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: actual stall=%b rdata=%h mis=%b required 0/0/0",
               bus0.stall_o, bus0.rdata_o, bus0.misalign_o);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (bus0.stall_o !== 1'b0 || bus0.rdata_o !== 32'd0 || bus0.misalign_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL idle_cycle%0d: actual stall=%b rdata=%h mis=%b required 0/0/0",
                 i, bus0.stall_o, bus0.rdata_o, bus0.misalign_o);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load(input int exp_stalls);
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, s, r, m, ma);
    check_access("store10", s, exp_stalls, r, 32'd0, m, 1'b0, ma);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, s, r, m, ma);
    check_access("load10", s, exp_stalls, r, 32'hDEADBEEF, m, 1'b0, ma);
  endtask

  task automatic test_wrap();
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b0, 1'b1, 32'h0, 32'h12345678, s, r, m, ma);
    check_access("store0", s, 3, r, 32'hDEADBEEF, m, 1'b0, ma);
    run_access(1'b1, 1'b0, 32'h400, 32'h0, s, r, m, ma);
    check_access("load400_wrap", s, 3, r, 32'h12345678, m, 1'b0, ma);
  endtask

  task automatic test_misalign();
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, s, r, m, ma);
    check_access("store12_misalign", s, 3, r, 32'd0, m, 1'b1, ma);
    run_access(1'b1, 1'b0, 32'h10, 32'h0, s, r, m, ma);
    check_access("load10_after_misalign", s, 3, r, 32'hDEADBEEF, m, 1'b0, ma);
  endtask

  task automatic test_reset_busy();
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b0, 1'b1, 32'h20, 32'h0, s, r, m, ma);
    check_access("store20_zero", s, 3, r, 32'hDEADBEEF, m, 1'b0, ma);
    memwrite = 1'b1;
    addr     = 32'h20;
    wdata    = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (bus0.stall_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL busy_before_reset: actual stall=%b required 1", bus0.stall_o);
    end
    rst      = 1'b1;
    memwrite = 1'b0;
    #1;
    compared++;
    if (bus0.stall_o !== 1'b0 || bus0.rdata_o !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_in_busy: actual stall=%b rdata=%h required 0/0",
               bus0.stall_o, bus0.rdata_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 32'h20, 32'h0, s, r, m, ma);
    check_access("load20_after_reset", s, 3, r, 32'h0, m, 1'b0, ma);
  endtask

  task automatic test_read_write_both();
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b1, 1'b0, 32'h10, 32'h0, s, r, m, ma);
    check_access("load10_prior", s, 3, r, 32'hDEADBEEF, m, 1'b0, ma);
    run_access(1'b1, 1'b1, 32'h30, 32'h0000BEEF, s, r, m, ma);
    check_access("rw30", s, 3, r, 32'hDEADBEEF, m, 1'b0, ma);
    run_access(1'b1, 1'b0, 32'h30, 32'h0, s, r, m, ma);
    check_access("load30", s, 3, r, 32'h0000BEEF, m, 1'b0, ma);
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] r; logic m, ma;
    run_access(1'b0, 1'b1, 32'h44, 32'h11112222, s, r, m, ma);
    check_access("b2b_store44", s, 3, r, 32'h0000BEEF, m, 1'b0, ma);
    run_access(1'b1, 1'b0, 32'h44, 32'h0, s, r, m, ma);
    check_access("b2b_load44", s, 3, r, 32'h11112222, m, 1'b0, ma);
    run_access(1'b1, 1'b0, 32'h0, 32'h0, s, r, m, ma);
    check_access("b2b_load0", s, 3, r, 32'h12345678, m, 1'b0, ma);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    sel        = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    addr       = 32'd0;
    wdata      = 32'd0;
    rst        = 1'b1;
    $display("[TB] starting dmem_ctrl bench");
    test_reset();
    test_idle();
    test_store_load(3);
    test_wrap();
    test_misalign();
    test_reset_busy();
    test_read_write_both();
    test_back_to_back();
    sel = 1'b1;
    @(posedge clk);
    #1;
    test_store_load(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
